imem_loader: RTL and testbench

Boot-time instruction-memory loader that sits directly upstream of the single-cycle core's fetch stage. Accepts a stream of 32-bit instruction words over a valid/ready handshake, writes them sequentially into instruction memory from address 0, and holds the core in reset with fetch disabled until loading completes. Then it releases the core: deasserts `core_rst` and asserts `core_en`.

---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory loader that holds the core in reset until the image is written
// Optional checksum word after the image: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              core_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_FLUSH,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                core_en_q, core_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     n_q, n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    logic                fire;
    logic                last_word;
    logic [ADDR_W:0]     eff_count;

    // Zero and anything beyond the memory depth both mean "fill the whole memory".
    assign eff_count = ((word_count == '0) || (word_count > DEPTH)) ? DEPTH : word_count;
    assign fire      = in_valid & in_ready_q;
    assign last_word = (count_q == (n_q - ONE));

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        core_en_d    = core_en_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        count_d      = count_q;
        n_d          = n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    n_d        = eff_count;
                    count_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    core_rst_d = 1'b1;
                    core_en_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (fire) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = count_q[ADDR_W-1:0];
                    imem_wdata_d = in_data;
                    count_d      = count_q + ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = sum_q + in_data;
                    if (last_word) begin
                        state_d = S_CHECK;
                    end
`else
                    if (last_word) begin
                        state_d    = S_FLUSH;
                        in_ready_d = 1'b0;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (fire) begin
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    if (in_data == sum_q) begin
                        state_d    = S_RUN;
                        core_rst_d = 1'b0;
                        core_en_d  = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_FLUSH: begin
                // Release lands on the same edge the final word is written.
                state_d    = S_RUN;
                core_rst_d = 1'b0;
                core_en_d  = 1'b1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            n_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
            n_q          <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign core_en    = core_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized streams and a queue-based image model
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic              core_en;
    logic              busy;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] fixed_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int eff_n(input int wc);
        return ((wc == 0) || (wc > DEPTH)) ? DEPTH : wc;
    endfunction

    // Monitor: every memory write must be the next word of the expected image.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h required=no write", imem_addr, imem_wdata);
            end else begin
                chk("wr_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
                chk("wr_data", 64'(imem_wdata), 64'(exp_data.pop_front()));
            end
        end
    end

    // gaps: 0 = in_valid steady, 1 = 1,0,0 repeating, 2 = random
    task automatic stream(input int n, input int gaps, output int sent, output logic [31:0] sum);
        int guard;
        bit v;
        logic [31:0] d;
        sent  = 0;
        sum   = 0;
        guard = 0;
        while (sent < n && guard < 4000) begin
            case (gaps)
                0:       v = 1'b1;
                1:       v = (guard % 3) == 0;
                default: v = ($urandom_range(0, 2) == 0);
            endcase
            d        = (fixed_q.size() > 0) ? fixed_q[0] : $urandom;
            in_valid = v;
            in_data  = d;
            if (v && in_ready === 1'b1) begin
                if (fixed_q.size() > 0) void'(fixed_q.pop_front());
                exp_addr.push_back(sent);
                exp_data.push_back(d);
                sum = sum + d;
                sent++;
            end
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic load(input int wc, input int gaps, input bit bad_sum);
        int n;
        int sent;
        logic [31:0] sum;
        n = eff_n(wc);
        @(negedge clk);
        start      = 1'b1;
        word_count = wc[ADDR_W:0];
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", 64'(in_ready), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("core_rst_in_load", 64'(core_rst), 64'd1);
        chk("done_in_load", 64'(done), 64'd0);
        stream(n, gaps, sent, sum);
        chk("words_accepted", 64'(sent), 64'(n));
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("ready_in_check", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = bad_sum ? sum + 32'd1 : sum;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("ready_after_check", 64'(in_ready), 64'd0);
        chk("done_after_check", 64'(done), bad_sum ? 64'd0 : 64'd1);
        chk("error_after_check", 64'(error), bad_sum ? 64'd1 : 64'd0);
        chk("core_en_after_check", 64'(core_en), bad_sum ? 64'd0 : 64'd1);
        chk("core_rst_after_check", 64'(core_rst), bad_sum ? 64'd1 : 64'd0);
        chk("busy_after_check", 64'(busy), 64'd0);
`else
        // Keep in_valid high through the flush cycle: no further word may be taken.
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("ready_low_after_last", 64'(in_ready), 64'd0);
        chk("done_low_in_flush", 64'(done), 64'd0);
        chk("core_en_low_in_flush", 64'(core_en), 64'd0);
        @(negedge clk);
        chk("done_released", 64'(done), 64'd1);
        chk("core_en_released", 64'(core_en), 64'd1);
        chk("core_rst_released", 64'(core_rst), 64'd0);
        chk("busy_cleared", 64'(busy), 64'd0);
        chk("error_tied_low", 64'(error), 64'd0);
        if (bad_sum) chk("bad_sum_unused", 64'(in_ready), 64'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("image_complete", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        int sent;
        logic [31:0] sum;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        rst = 1'b0;

        fixed_q.push_back(32'h00500093);
        fixed_q.push_back(32'h00300113);
        fixed_q.push_back(32'h002081B3);
        load(3, 0, 1'b0);
        load(4, 1, 1'b0);
        load(0, 2, 1'b0);
        load(40, 0, 1'b0);
        for (int k = 0; k < 4; k++) load($urandom_range(1, 33), 2, 1'b0);

        // Abort after two of five words; the next load must start again at address 0.
        @(negedge clk);
        start      = 1'b1;
        word_count = 6'd5;
        @(negedge clk);
        start = 1'b0;
        stream(2, 0, sent, sum);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_core_rst", 64'(core_rst), 64'd1);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_imem_we", 64'(imem_we), 64'd0);
        chk("abort_queue", 64'(exp_addr.size()), 64'd0);
        load(5, 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        fixed_q.push_back(32'd1);
        fixed_q.push_back(32'd2);
        fixed_q.push_back(32'd3);
        load(3, 0, 1'b0);
        fixed_q.push_back(32'd1);
        fixed_q.push_back(32'd2);
        fixed_q.push_back(32'd3);
        load(3, 0, 1'b1);
        load(3, 2, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 64'(exp_addr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
